// File: rtl/dsp_mac_slice.sv
// dsp_mac_slice: parametrised multiply-accumulate slice.
// The datapath is a pre-adder, a multiplier, and a post-adder/accumulator.
// A valid bit travels with each sample through optional input (IN_REG) and
// multiplier (MREG) register stages, ending in the P register.
// Latency is IN_REG + MREG + 1 cycles.
// Optional feature macro: DSP_MAC_SAT_EN. When defined, P saturates on
// overflow; otherwise P wraps.
module dsp_mac_slice #(
  parameter int A_W    = 18,
  parameter int B_W    = 18,
  parameter int P_W    = 48,
  parameter int SIGNED = 1,
  parameter int IN_REG = 1,
  parameter int MREG   = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  input  logic [A_W-1:0]   A,
  input  logic [B_W-1:0]   B,
  input  logic [B_W-1:0]   D,
  input  logic [P_W-1:0]   C,
  input  logic [P_W-1:0]   PCIN,
  input  logic [4:0]       OPMODE,
  input  logic             CLR_OVF,
  output logic [P_W-1:0]   P,
  output logic [P_W-1:0]   PCOUT,
  output logic             OUT_VALID,
  output logic             OVF
);

  localparam int PRE_W = B_W + 1;
  localparam int M_W   = A_W + B_W + 1;
  localparam int F_W   = P_W + 2;

  generate
    if (P_W < A_W + B_W + 1) begin : g_bad_pw
      $error("dsp_mac_slice: P_W must be at least A_W+B_W+1");
    end
  endgenerate

  // Extension bit: the sign bit for two's-complement arithmetic, zero otherwise.
  function automatic logic ext_bit(input logic msb);
    if (SIGNED != 0) begin
      return msb;
    end else begin
      return 1'b0;
    end
  endfunction

  // ---------------- Input stage ----------------
  logic             s0_valid_s;
  logic [A_W-1:0]   s0_a_s;
  logic [B_W-1:0]   s0_b_s;
  logic [B_W-1:0]   s0_d_s;
  logic [P_W-1:0]   s0_c_s;
  logic [P_W-1:0]   s0_pcin_s;
  logic [4:0]       s0_op_s;

  generate
    if (IN_REG != 0) begin : g_in_reg
      logic             valid_r;
      logic [A_W-1:0]   a_r;
      logic [B_W-1:0]   b_r;
      logic [B_W-1:0]   d_r;
      logic [P_W-1:0]   c_r;
      logic [P_W-1:0]   pcin_r;
      logic [4:0]       op_r;

      // Input register: the valid bit always shifts; data loads only for valid samples.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          valid_r <= 1'b0;
          a_r     <= {A_W{1'b0}};
          b_r     <= {B_W{1'b0}};
          d_r     <= {B_W{1'b0}};
          c_r     <= {P_W{1'b0}};
          pcin_r  <= {P_W{1'b0}};
          op_r    <= 5'b00000;
        end else begin
          valid_r <= IN_VALID;
          if (IN_VALID) begin
            a_r    <= A;
            b_r    <= B;
            d_r    <= D;
            c_r    <= C;
            pcin_r <= PCIN;
            op_r   <= OPMODE;
          end
        end
      end

      assign s0_valid_s = valid_r;
      assign s0_a_s     = a_r;
      assign s0_b_s     = b_r;
      assign s0_d_s     = d_r;
      assign s0_c_s     = c_r;
      assign s0_pcin_s  = pcin_r;
      assign s0_op_s    = op_r;
    end else begin : g_in_comb
      assign s0_valid_s = IN_VALID;
      assign s0_a_s     = A;
      assign s0_b_s     = B;
      assign s0_d_s     = D;
      assign s0_c_s     = C;
      assign s0_pcin_s  = PCIN;
      assign s0_op_s    = OPMODE;
    end
  endgenerate

  // ---------------- Pre-adder and multiplier ----------------
  logic [PRE_W-1:0] b_x_s;
  logic [PRE_W-1:0] d_x_s;
  logic [PRE_W-1:0] pre_s;
  logic [M_W-1:0]   a_m_s;
  logic [M_W-1:0]   pre_m_s;
  logic [M_W-1:0]   m_s;

  // Compute the pre-adder and the product. Operands are extended to the
  // full product width, so the low M_W bits form the exact product.
  always_comb begin
    b_x_s = {ext_bit(s0_b_s[B_W-1]), s0_b_s};
    d_x_s = {ext_bit(s0_d_s[B_W-1]), s0_d_s};
    if (s0_op_s[0]) begin
      if (s0_op_s[1]) begin
        pre_s = d_x_s - b_x_s;
      end else begin
        pre_s = d_x_s + b_x_s;
      end
    end else begin
      pre_s = b_x_s;
    end
    a_m_s   = {{(M_W-A_W){ext_bit(s0_a_s[A_W-1])}}, s0_a_s};
    pre_m_s = {{(M_W-PRE_W){ext_bit(pre_s[PRE_W-1])}}, pre_s};
    m_s     = a_m_s * pre_m_s;
  end

  // ---------------- Multiplier stage ----------------
  logic             s1_valid_s;
  logic [M_W-1:0]   s1_m_s;
  logic [P_W-1:0]   s1_c_s;
  logic [P_W-1:0]   s1_pcin_s;
  logic [4:0]       s1_op_s;

  generate
    if (MREG != 0) begin : g_m_reg
      logic             valid_r;
      logic [M_W-1:0]   m_r;
      logic [P_W-1:0]   c_r;
      logic [P_W-1:0]   pcin_r;
      logic [4:0]       op_r;

      // Multiplier register: the product travels with its own C, PCIN and OPMODE.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          valid_r <= 1'b0;
          m_r     <= {M_W{1'b0}};
          c_r     <= {P_W{1'b0}};
          pcin_r  <= {P_W{1'b0}};
          op_r    <= 5'b00000;
        end else begin
          valid_r <= s0_valid_s;
          if (s0_valid_s) begin
            m_r    <= m_s;
            c_r    <= s0_c_s;
            pcin_r <= s0_pcin_s;
            op_r   <= s0_op_s;
          end
        end
      end

      assign s1_valid_s = valid_r;
      assign s1_m_s     = m_r;
      assign s1_c_s     = c_r;
      assign s1_pcin_s  = pcin_r;
      assign s1_op_s    = op_r;
    end else begin : g_m_comb
      assign s1_valid_s = s0_valid_s;
      assign s1_m_s     = m_s;
      assign s1_c_s     = s0_c_s;
      assign s1_pcin_s  = s0_pcin_s;
      assign s1_op_s    = s0_op_s;
    end
  endgenerate

  // ---------------- Post-adder, overflow, P register ----------------
  logic [P_W-1:0] p_r;
  logic           out_valid_r;
  logic           ovf_r;
  logic [P_W-1:0] z_s;
  logic [F_W-1:0] z_x_s;
  logic [F_W-1:0] m_x_s;
  logic [F_W-1:0] full_s;
  logic           ovf_s;
  logic [P_W-1:0] p_next_s;
  logic           ovf_next_s;

  // Select Z, then add or subtract the product in a two-bit-wider domain.
  // The extra bits make carry, borrow and signed overflow directly visible.
  always_comb begin
    case (s1_op_s[3:2])
      2'b00:   z_s = {P_W{1'b0}};
      2'b01:   z_s = s1_c_s;
      2'b10:   z_s = p_r;
      2'b11:   z_s = s1_pcin_s;
      default: z_s = {P_W{1'b0}};
    endcase
    z_x_s = {{2{ext_bit(z_s[P_W-1])}}, z_s};
    m_x_s = {{(F_W-M_W){ext_bit(s1_m_s[M_W-1])}}, s1_m_s};
    if (s1_op_s[4]) begin
      full_s = z_x_s - m_x_s;
    end else begin
      full_s = z_x_s + m_x_s;
    end
    if (SIGNED != 0) begin
      ovf_s = (full_s[F_W-1] != full_s[F_W-2]) || (full_s[F_W-2] != full_s[F_W-3]);
    end else begin
      ovf_s = (full_s[F_W-1:F_W-2] != 2'b00);
    end
`ifdef DSP_MAC_SAT_EN
    if (ovf_s) begin
      if (SIGNED != 0) begin
        if (full_s[F_W-1]) begin
          p_next_s = {1'b1, {(P_W-1){1'b0}}};
        end else begin
          p_next_s = {1'b0, {(P_W-1){1'b1}}};
        end
      end else begin
        if (s1_op_s[4]) begin
          p_next_s = {P_W{1'b0}};
        end else begin
          p_next_s = {P_W{1'b1}};
        end
      end
    end else begin
      p_next_s = full_s[P_W-1:0];
    end
`else
    p_next_s = full_s[P_W-1:0];
`endif
    // A new overflow wins over a simultaneous clear.
    ovf_next_s = (s1_valid_s & ovf_s) | (ovf_r & ~CLR_OVF);
  end

  // P register with sticky overflow: P updates only for valid samples.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      p_r         <= {P_W{1'b0}};
      out_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      out_valid_r <= s1_valid_s;
      ovf_r       <= ovf_next_s;
      if (s1_valid_s) begin
        p_r <= p_next_s;
      end else begin
        p_r <= p_r;
      end
    end
  end

  assign P         = p_r;
  assign PCOUT     = p_r;
  assign OUT_VALID = out_valid_r;
  assign OVF       = ovf_r;

endmodule

// File: tb/tb_dsp_mac_slice.sv
// Self-checking bench for dsp_mac_slice at default parameters (L = 3).
// A plain-integer reference model predicts OUT_VALID, P, PCOUT and OVF on
// every cycle. Directed scenarios add hand-computed literal expectations.
module tb_dsp_mac_slice;

  localparam longint MAXP = 64'sd140737488355327;
  localparam longint MINP = -64'sd140737488355328;

  logic        CLK;
  logic        RST_N;
  logic        IN_VALID;
  logic [17:0] A;
  logic [17:0] B;
  logic [17:0] D;
  logic [47:0] C;
  logic [47:0] PCIN;
  logic [4:0]  OPMODE;
  logic        CLR_OVF;
  logic [47:0] P;
  logic [47:0] PCOUT;
  logic        OUT_VALID;
  logic        OVF;

  int checks;
  int failures;

  dsp_mac_slice dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .A(A), .B(B), .D(D),
    .C(C), .PCIN(PCIN), .OPMODE(OPMODE), .CLR_OVF(CLR_OVF),
    .P(P), .PCOUT(PCOUT), .OUT_VALID(OUT_VALID), .OVF(OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- Reference model ----------------
  typedef struct {
    logic        v;
    logic [17:0] a;
    logic [17:0] b;
    logic [17:0] d;
    logic [47:0] c;
    logic [47:0] pcin;
    logic [4:0]  op;
  } smp_t;

  smp_t        pipe[$];
  logic [47:0] m_p;
  logic        m_v;
  logic        m_ovf;

  // Evaluate one sample arithmetically.
  function automatic void apply(input smp_t s, input logic [47:0] pin,
                                output logic [47:0] pout, output logic ov);
    longint a, b, d, pre, m, z, r;
    a = longint'($signed(s.a));
    b = longint'($signed(s.b));
    d = longint'($signed(s.d));
    if (s.op[0]) pre = s.op[1] ? (d - b) : (d + b);
    else         pre = b;
    m = a * pre;
    case (s.op[3:2])
      2'b00:   z = 0;
      2'b01:   z = longint'($signed(s.c));
      2'b10:   z = longint'($signed(pin));
      default: z = longint'($signed(s.pcin));
    endcase
    r  = s.op[4] ? (z - m) : (z + m);
    ov = (r > MAXP) || (r < MINP);
`ifdef DSP_MAC_SAT_EN
    if (ov) r = (r > MAXP) ? MAXP : MINP;
`endif
    pout = r[47:0];
  endfunction

  // Model: a sample captured at edge n takes effect at edge n+2.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pipe.delete();
      m_p   <= 48'h0;
      m_v   <= 1'b0;
      m_ovf <= 1'b0;
    end else begin
      smp_t        s;
      smp_t        cur;
      logic [47:0] np;
      logic        nov;
      logic        nv;
      np  = m_p;
      nov = 1'b0;
      nv  = 1'b0;
      if (pipe.size() == 2) begin
        s = pipe.pop_front();
        if (s.v) begin
          apply(s, m_p, np, nov);
          nv = 1'b1;
        end
      end
      m_p   <= np;
      m_v   <= nv;
      m_ovf <= nov | (m_ovf & ~CLR_OVF);
      cur.v = IN_VALID; cur.a = A; cur.b = B; cur.d = D;
      cur.c = C; cur.pcin = PCIN; cur.op = OPMODE;
      pipe.push_back(cur);
    end
  end

  // Compare the DUT against the model on every falling edge out of reset.
  always @(negedge CLK) begin
    if (RST_N) begin
      check("out_valid", {63'h0, OUT_VALID}, {63'h0, m_v});
      check("p",         {16'h0, P},         {16'h0, m_p});
      check("pcout",     {16'h0, PCOUT},     {16'h0, m_p});
      check("ovf",       {63'h0, OVF},       {63'h0, m_ovf});
    end
  end

  // ---------------- Stimulus ----------------
  task automatic drive(input logic v, input logic [17:0] a, input logic [17:0] b,
                       input logic [17:0] d, input logic [47:0] c, input logic [47:0] pcin,
                       input logic [4:0] op, input logic clr);
    IN_VALID = v; A = a; B = b; D = d; C = c; PCIN = pcin; OPMODE = op; CLR_OVF = clr;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input logic clr);
    drive(1'b0, 18'h0, 18'h0, 18'h0, 48'h0, 48'h0, 5'b00000, clr);
  endtask

`ifdef DSP_MAC_SAT_EN
  localparam logic [47:0] OVF_P = 48'h7FFF_FFFF_FFFF;
`else
  localparam logic [47:0] OVF_P = 48'h8000_0000_0000;
`endif

  initial begin
    checks = 0;
    failures = 0;
    RST_N = 1'b0;
    IN_VALID = 1'b0; A = 18'h0; B = 18'h0; D = 18'h0;
    C = 48'h0; PCIN = 48'h0; OPMODE = 5'b00000; CLR_OVF = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check("reset_p", {16'h0, P}, 64'h0);
    check("reset_valid", {63'h0, OUT_VALID}, 64'h0);
    check("reset_ovf", {63'h0, OVF}, 64'h0);
    RST_N = 1'b1;

    // 1. Plain multiply: 3 * 5
    drive(1'b1, 18'd3, 18'd5, 18'd0, 48'h0, 48'h0, 5'b00000, 1'b0);
    idle(1'b0);
    check("mul_valid_early", {63'h0, OUT_VALID}, 64'h0);
    idle(1'b0);
    check("mul_p", {16'h0, P}, 64'd15);
    check("mul_valid", {63'h0, OUT_VALID}, 64'd1);
    idle(1'b0);
    check("mul_valid_low", {63'h0, OUT_VALID}, 64'h0);
    check("mul_p_hold", {16'h0, P}, 64'd15);

    // 2. Pre-subtract: -2 * (10 - 4)
    drive(1'b1, -18'sd2, 18'd4, 18'd10, 48'h0, 48'h0, 5'b00011, 1'b0);
    idle(1'b0);
    idle(1'b0);
    check("presub_p", {16'h0, P}, {16'h0, 48'hFFFF_FFFF_FFF4});

    // 3. Back-to-back accumulate: B=2, A=1..4
    drive(1'b1, 18'd1, 18'd2, 18'd0, 48'h0, 48'h0, 5'b00000, 1'b0);
    drive(1'b1, 18'd2, 18'd2, 18'd0, 48'h0, 48'h0, 5'b01000, 1'b0);
    drive(1'b1, 18'd3, 18'd2, 18'd0, 48'h0, 48'h0, 5'b01000, 1'b0);
    check("acc_p0", {16'h0, P}, 64'd2);
    drive(1'b1, 18'd4, 18'd2, 18'd0, 48'h0, 48'h0, 5'b01000, 1'b0);
    check("acc_p1", {16'h0, P}, 64'd6);
    idle(1'b0);
    check("acc_p2", {16'h0, P}, 64'd12);
    idle(1'b0);
    check("acc_p3", {16'h0, P}, 64'd20);
    check("acc_valid", {63'h0, OUT_VALID}, 64'd1);

    // 4. Overflow, clear, and clear colliding with a new overflow
    drive(1'b1, 18'd1, 18'd1, 18'd0, 48'h7FFF_FFFF_FFFF, 48'h0, 5'b00100, 1'b0);
    idle(1'b0);
    idle(1'b0);
    check("ovf_p", {16'h0, P}, {16'h0, OVF_P});
    check("ovf_set", {63'h0, OVF}, 64'd1);
    idle(1'b1);
    check("ovf_cleared", {63'h0, OVF}, 64'h0);
    drive(1'b1, 18'd1, 18'd1, 18'd0, 48'h7FFF_FFFF_FFFF, 48'h0, 5'b00100, 1'b0);
    idle(1'b0);
    idle(1'b1);
    check("ovf_set_wins", {63'h0, OVF}, 64'd1);

    // 5. Bubbles: products 6 and 7 with a gap between them
    drive(1'b1, 18'd2, 18'd3, 18'd0, 48'h0, 48'h0, 5'b00000, 1'b0);
    idle(1'b0);
    drive(1'b1, 18'd7, 18'd1, 18'd0, 48'h0, 48'h0, 5'b00000, 1'b0);
    check("bub_p0", {16'h0, P}, 64'd6);
    check("bub_v0", {63'h0, OUT_VALID}, 64'd1);
    idle(1'b0);
    check("bub_p1", {16'h0, P}, 64'd6);
    check("bub_v1", {63'h0, OUT_VALID}, 64'h0);
    idle(1'b0);
    check("bub_p2", {16'h0, P}, 64'd7);
    check("bub_v2", {63'h0, OUT_VALID}, 64'd1);

    // 7. Pre-add, PCIN cascade, post-subtract, large signed operands
    drive(1'b1, 18'd3, 18'd2, 18'd5, 48'h0, 48'h0, 5'b00001, 1'b0);
    drive(1'b1, 18'd2, 18'd3, 18'd0, 48'h0, 48'd100, 5'b01100, 1'b0);
    drive(1'b1, 18'd3, 18'd4, 18'd0, 48'd50, 48'h0, 5'b10100, 1'b0);
    check("preadd_p", {16'h0, P}, 64'd21);
    drive(1'b1, -18'sd131072, 18'd131071, -18'sd131072, 48'h0, 48'h0, 5'b00011, 1'b0);
    check("pcin_p", {16'h0, P}, 64'd106);
    idle(1'b0);
    check("postsub_p", {16'h0, P}, 64'd38);
    idle(1'b0);
    check("big_p", {16'h0, P}, 64'd34359607296);
    idle(1'b0);

    // 6. Reset mid-operation; OVF is still set from the overflow tests
    drive(1'b1, 18'd3, 18'd3, 18'd0, 48'h0, 48'h0, 5'b00000, 1'b0);
    IN_VALID = 1'b0;
    #1;
    RST_N = 1'b0;
    #1;
    check("rst_p", {16'h0, P}, 64'h0);
    check("rst_valid", {63'h0, OUT_VALID}, 64'h0);
    check("rst_ovf", {63'h0, OVF}, 64'h0);
    #1;
    RST_N = 1'b1;
    idle(1'b0);
    check("rst_drop0", {63'h0, OUT_VALID}, 64'h0);
    idle(1'b0);
    check("rst_drop1", {63'h0, OUT_VALID}, 64'h0);
    drive(1'b1, 18'd4, 18'd5, 18'd0, 48'h0, 48'h0, 5'b00000, 1'b0);
    idle(1'b0);
    check("rst_next_early", {63'h0, OUT_VALID}, 64'h0);
    idle(1'b0);
    check("rst_next_p", {16'h0, P}, 64'd20);
    check("rst_next_valid", {63'h0, OUT_VALID}, 64'd1);
    idle(1'b0);
    idle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dsp_mac_slice.md
# dsp_mac_slice

Parametrised multiply-accumulate slice, the successor to the fixed 18x18/48 DSP slice. Per-sample pre-adder, multiplier, post-adder/accumulator with a valid-tagged pipeline. Configurable operand widths, signedness, pipeline depth and overflow tracking. Sits in the datapath wherever a cascaded MAC or FIR tap is needed; chains through `PCIN`/`PCOUT`.

## Interface
- `A_W`, default 18: width of the A operand.
- `B_W`, default 18: width of the B and D operands.
- `P_W`, default 48: width of the accumulator and of C, PCIN and P. Must be ≥ A_W+B_W+1; elaboration error otherwise.
- `SIGNED`, default 1: 1 means two's-complement arithmetic, 0 means unsigned.
- `IN_REG`, default 1: 0 or 1; input register stage.
- `MREG`, default 1: 0 or 1; multiplier output register stage.

- `CLK` input 1: single clock, rising edge.
- `RST_N` input 1: reset, asynchronous assert, active-low.
- `IN_VALID` input 1: A, B, D, C, PCIN and OPMODE are valid this cycle.
- `A` input A_W: multiplier operand.
- `B` input B_W: multiplier operand and pre-adder operand.
- `D` input B_W: pre-adder operand.
- `C` input P_W: post-adder operand.
- `PCIN` input P_W: cascade input.
- `OPMODE` input 5:
  - [0] PRE_EN
  - [1] PRE_SUB
  - [3:2] ZSEL: 00 zero, 01 C, 10 P, 11 PCIN
  - [4] POST_SUB
- `CLR_OVF` input 1: clears the sticky overflow flag.
- `P` output P_W: result or accumulator.
- `PCOUT` output P_W: equal to P.
- `OUT_VALID` output 1: P was updated on the last edge.
- `OVF` output 1: sticky overflow flag.

## Operation
- **Stage-by-stage flow.** OPMODE travels with its sample through every stage. There is no global OPMODE register.
- **Pre-adder.**
  - Width is B_W+1, with no truncation.
  - PRE_EN=0: the multiplier's B input is B, sign- or zero-extended.
  - PRE_EN=1, PRE_SUB=0: D+B.
  - PRE_EN=1, PRE_SUB=1: D−B.
- **Multiplier.** M = A × pre-adder output, A_W+B_W+1 bits. M is extended to P_W according to SIGNED.
- **Post-adder.** Z is selected by ZSEL.
  - POST_SUB=0: result = Z + M.
  - POST_SUB=1: result = Z − M.
- **Accumulator feedback.** ZSEL=P uses the P register value at the edge where the sample enters the P stage. Back-to-back accumulations therefore chain with no bubble.
- **Overflow detection.**
  - SIGNED=1: the true result falls outside [−2^(P_W−1), 2^(P_W−1)−1].
  - SIGNED=0: carry out on add, or borrow on subtract.
- **Overflow handling.** On overflow OVF sets and stays set until CLR_OVF or reset. The P value depends on DSP_MAC_SAT_EN (see Configuration).
- **CLR_OVF conflict.** CLR_OVF=1 in the same cycle as a new overflow: the set wins and OVF stays 1.
- **Bubbles.** With IN_VALID=0 the valid bit shifts in as 0. Data registers of invalid stages may hold. P, OVF and PCOUT hold their value.
- **Reset.** RST_N=0, asynchronously:
  - All pipeline registers, P, PCOUT, OUT_VALID and OVF go to 0.
  - In-flight samples are discarded.
  - The first edge after deassertion accepts new input normally.

## Timing
- **Latency.** L = IN_REG + MREG + 1; the P register is always present. Default L = 3.
- A sample presented with IN_VALID=1 at edge n appears in P, with OUT_VALID=1, after edge n+L−1.
  - Example, defaults: IN_VALID high during cycle 0 gives OUT_VALID high in cycle 3.
- **Throughput.** One sample per cycle. No backpressure: downstream must accept every OUT_VALID pulse.
- **OUT_VALID** is high for exactly one cycle per accepted sample. Input gaps are preserved exactly at the output.
- **OVF** updates on the same edge as the P register it refers to.
- **CLR_OVF** takes effect on the next edge.

## Configuration
- Macro: `DSP_MAC_SAT_EN`.
- **Defined:** on overflow, P saturates.
  - SIGNED=1: to 2^(P_W−1)−1 (positive overflow) or −2^(P_W−1) (negative overflow).
  - SIGNED=0: to all-ones (add) or 0 (subtract).
- **Undefined:** P takes the wrapped modulo-2^P_W result.
- OVF behaviour is identical in both builds.

## Test plan
All scenarios use default parameters (L = 3).
1. **Plain multiply.** IN_VALID=1 once with A=3, B=5, OPMODE=00000 → cycle 3: P=15, OUT_VALID=1. Cycle 4: OUT_VALID=0 and P holds 15.
2. **Pre-subtract.** D=10, B=4, A=−2, OPMODE=00011 → P=−12, i.e. 0xFFFF_FFFF_FFF4.
3. **Back-to-back accumulate.** Four consecutive samples with B=2 and A=1, 2, 3, 4.
   - OPMODE: first 00000, then 01000 (ZSEL=P).
   - Expected: P=2, 6, 12, 20 on four consecutive OUT_VALID cycles.
4. **Overflow and clear.** C=2^47−1, A=1, B=1, OPMODE=00100.
   - Without the macro: P=−2^47 and OVF=1. With the macro: P=2^47−1 and OVF=1.
   - Then CLR_OVF=1 with no overflowing sample → OVF=0 next cycle.
   - CLR_OVF=1 coinciding with an overflowing result → OVF stays 1.
5. **Bubbles.** IN_VALID pattern 1,0,1 with products 6 and 7 → OUT_VALID 1,0,1 in cycles 3–5. P=6, then 6, then 7.
6. **Reset mid-operation.** Pulse RST_N low during cycle 1 after a sample with product 9.
   - P, OUT_VALID and OVF read 0 immediately.
   - No OUT_VALID occurs for the dropped sample.
   - The next sample produces its result L cycles after it is presented.
